fft_run_sequencer: RTL and testbench

Sequences repeated FFT self-test runs. Per run: pulse the FFT start, wait for FFT completion, wait a settle gap, pulse the result checker, collect its pass/fail verdict. Sits between top-level start/done and the fft / mem_check pair. Replaces the ad-hoc SR-latch/pulse logic with one FSM that has pass/fail counters and a watchdog.

---
 rtl/fft_run_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_run_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_run_sequencer.sv
// rtl/fft_run_sequencer.sv - repeated FFT self-test run sequencer
// One FSM runs NUM_RUNS fft/check cycles with pass/fail counters and a watchdog.
module fft_run_sequencer #(
  parameter int NUM_RUNS = 4,
  parameter int SETTLE   = 5,
  parameter int TIMEOUT  = 1024,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fft_done,
  input  logic          comp_done,
  input  logic          check_q,
  output logic          start_fft,
  output logic          start_comp,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [CW-1:0] run_idx,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count
);

  // Shared by the watchdog and the settle gap, so sized for the larger of the two.
  localparam int WW = $clog2(TIMEOUT + SETTLE + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FFT_START,
    S_FFT_WAIT,
    S_SETTLE,
    S_CHK_START,
    S_CHK_WAIT,
    S_RECORD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] wait_cnt;
  logic          fft_d;
  logic          comp_d;
  logic          verdict;

  logic fft_rise;
  logic comp_rise;
  logic last_run;
  logic wait_expired;
  logic settle_over;
  logic clr_runs;
  logic clr_wait;
  logic inc_wait;
  logic take_verdict;
  logic record;

  assign fft_rise     = fft_done & ~fft_d;
  assign comp_rise    = comp_done & ~comp_d;
  assign last_run     = (run_idx == CW'(NUM_RUNS - 1));
  assign wait_expired = (wait_cnt == WW'(TIMEOUT - 1));
  assign settle_over  = (wait_cnt == WW'(SETTLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_runs     = 1'b0;
    clr_wait     = 1'b0;
    inc_wait     = 1'b0;
    take_verdict = 1'b0;
    record       = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_FFT_START;
          clr_runs   = 1'b1;
        end
      end
      S_FFT_START: begin
        state_next = S_FFT_WAIT;
        clr_wait   = 1'b1;
      end
      S_FFT_WAIT: begin
        if (fft_rise) begin
          state_next = (SETTLE == 0) ? S_CHK_START : S_SETTLE;
          clr_wait   = 1'b1;
        end else if (wait_expired) begin
          state_next = S_ERROR;
        end else begin
          inc_wait = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_over) begin
          state_next = S_CHK_START;
        end else begin
          inc_wait = 1'b1;
        end
      end
      S_CHK_START: begin
        state_next = S_CHK_WAIT;
        clr_wait   = 1'b1;
      end
      S_CHK_WAIT: begin
        if (comp_rise) begin
          state_next   = S_RECORD;
          take_verdict = 1'b1;
        end else if (wait_expired) begin
          state_next = S_ERROR;
        end else begin
          inc_wait = 1'b1;
        end
      end
      S_RECORD: begin
        record     = 1'b1;
        state_next = last_run ? S_DONE : S_FFT_START;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // An aborted run never reaches RECORD, so it lands in neither counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fft_d      <= 1'b0;
      comp_d     <= 1'b0;
      wait_cnt   <= '0;
      verdict    <= 1'b0;
      run_idx    <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      fft_d  <= fft_done;
      comp_d <= comp_done;
      if (clr_wait) begin
        wait_cnt <= '0;
      end else if (inc_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (take_verdict) begin
        verdict <= check_q;
      end
      if (clr_runs) begin
        run_idx    <= '0;
        pass_count <= '0;
        fail_count <= '0;
      end else if (record) begin
        if (verdict) begin
          pass_count <= pass_count + 1'b1;
        end else begin
          fail_count <= fail_count + 1'b1;
        end
        if (!last_run) begin
          run_idx <= run_idx + 1'b1;
        end
      end
    end
  end

  assign start_fft   = (state == S_FFT_START);
  assign start_comp  = (state == S_CHK_START);
  assign busy        = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign done        = (state == S_DONE) || (state == S_ERROR);
  assign timeout_err = (state == S_ERROR);

endmodule

// File: tb/tb_fft_run_sequencer.sv
// tb/tb_fft_run_sequencer.sv - scoreboard bench for fft_run_sequencer
// Behavioural fft/checker models feed expectation queues that a monitor drains.
module tb_fft_run_sequencer;

  localparam int TO      = 64;
  localparam int R1      = 4;
  localparam int S1      = 5;
  localparam int R2      = 1;
  localparam int S2      = 0;
  localparam int FFT_LAT = 40;
  localparam int CHK_LAT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic fft_model = 1'b1;
  logic fft_spur_a = 1'b0;
  logic fft_spur_b = 1'b0;
  logic comp_model = 1'b0;
  logic check_q = 1'b0;
  logic fft_done, comp_done, start1, start2;

  logic sf1, sc1, busy1, done1, terr1;
  logic [7:0] ri1, pc1, fc1;
  logic sf2, sc2, busy2, done2, terr2;
  logic [7:0] ri2, pc2, fc2;
  logic sf_m, sc_m, busy_m, done_m, terr_m;
  logic [7:0] ri_m, pc_m, fc_m;
  int runs_now, settle_now;

  assign fft_done   = fft_model ^ fft_spur_a ^ fft_spur_b;
  assign comp_done  = comp_model;
  assign start1     = start & ~sel;
  assign start2     = start & sel;
  assign sf_m       = sel ? sf2 : sf1;
  assign sc_m       = sel ? sc2 : sc1;
  assign busy_m     = sel ? busy2 : busy1;
  assign done_m     = sel ? done2 : done1;
  assign terr_m     = sel ? terr2 : terr1;
  assign ri_m       = sel ? ri2 : ri1;
  assign pc_m       = sel ? pc2 : pc1;
  assign fc_m       = sel ? fc2 : fc1;
  assign runs_now   = sel ? R2 : R1;
  assign settle_now = sel ? S2 : S1;

  fft_run_sequencer #(.NUM_RUNS(R1), .SETTLE(S1), .TIMEOUT(TO), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .fft_done(fft_done), .comp_done(comp_done),
    .check_q(check_q), .start_fft(sf1), .start_comp(sc1), .busy(busy1), .done(done1),
    .timeout_err(terr1), .run_idx(ri1), .pass_count(pc1), .fail_count(fc1));

  fft_run_sequencer #(.NUM_RUNS(R2), .SETTLE(S2), .TIMEOUT(TO), .CW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .fft_done(fft_done), .comp_done(comp_done),
    .check_q(check_q), .start_fft(sf2), .start_comp(sc2), .busy(busy2), .done(done2),
    .timeout_err(terr2), .run_idx(ri2), .pass_count(pc2), .fail_count(fc2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pass;
    int fail;
    int ridx;
    int terr;
    int nfft;
    int ncomp;
    int tdelta;
  } exp_t;

  exp_t exp_q[$];
  int   exp_comp_q[$];
  bit   verdict_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  int   nfft = 0;
  int   ncomp = 0;
  int   last_sf_cyc = 0;
  bit   fft_hang = 1'b0;
  bit   spur_en = 1'b0;
  bit   rand_lat = 1'b0;
  bit   chk_active = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One plan = one start..done episode; expectations derive from the verdict list alone.
  task automatic queue_plan(input int runs, input bit rnd, input int fail_run);
    exp_t e;
    bit v;
    e = '{pass: 0, fail: 0, ridx: runs - 1, terr: 0, nfft: runs, ncomp: runs, tdelta: 0};
    for (int i = 0; i < runs; i++) begin
      v = rnd ? 1'($urandom_range(1, 0)) : (i != fail_run);
      verdict_q.push_back(v);
      if (v) e.pass++;
      else e.fail++;
    end
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (n_done < target && n < limit) begin
      tick();
      n++;
    end
    check({name, " done reached"}, n_done, target);
  endtask

  // FFT model: drops fft_done the cycle after start_fft, raises it lat cycles later.
  initial begin : fft_proc
    int lat;
    int t0;
    forever begin
      @(negedge clk);
      if (sf_m === 1'b1) begin
        lat = rand_lat ? int'($urandom_range(45, 10)) : FFT_LAT;
        t0  = cyc;
        tick();
        fft_model = 1'b0;
        while (cyc < t0 + 1 + lat) tick();
        if (!fft_hang) begin
          fft_model = 1'b1;
          exp_comp_q.push_back(cyc + 1 + settle_now);
          if (spur_en) begin
            tick();
            fft_spur_a = 1'b1;
            tick();
            fft_spur_a = 1'b0;
          end
        end
      end
    end
  end

  // Checker model: comp_done rises lat cycles after start_comp with the planned verdict.
  initial begin : chk_proc
    int lat;
    int t0;
    bit v;
    forever begin
      @(negedge clk);
      if (sc_m === 1'b1) begin
        lat = rand_lat ? int'($urandom_range(40, 3)) : CHK_LAT;
        v   = (verdict_q.size() > 0) ? verdict_q.pop_front() : 1'b1;
        t0  = cyc;
        chk_active = 1'b1;
        tick();
        comp_model = 1'b0;
        check_q    = 1'($urandom_range(1, 0));
        if (spur_en && lat >= 4) begin
          tick();
          fft_spur_b = 1'b1;
          tick();
          fft_spur_b = 1'b0;
        end
        while (cyc < t0 + lat) tick();
        check_q    = v;
        comp_model = 1'b1;
        tick();
        check_q    = ~v;
        chk_active = 1'b0;
      end
    end
  end

  initial begin : monitor_proc
    logic sf_prev, sc_prev, done_prev;
    bit pend_rerun;
    exp_t e;
    sf_prev = 1'b0;
    sc_prev = 1'b0;
    done_prev = 1'b0;
    pend_rerun = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nfft = 0;
        ncomp = 0;
        pend_rerun = 1'b0;
      end else begin
        if (pend_rerun) begin
          check("rerun start_fft after done", int'(sf_m), 1);
          pend_rerun = 1'b0;
        end
        check("start_fft/start_comp overlap", int'(sf_m & sc_m), 0);
        check("start_fft two cycles", int'(sf_m & sf_prev), 0);
        check("start_comp two cycles", int'(sc_m & sc_prev), 0);
        check("pass+fail bound", int'(int'(pc_m) + int'(fc_m) <= runs_now), 1);
        if (sf_m) begin
          check("run_idx at start_fft", int'(ri_m), nfft);
          check("busy/done/terr at start_fft", int'({busy_m, done_m, terr_m}), 4);
          nfft++;
          last_sf_cyc = cyc;
        end
        if (sc_m) begin
          ncomp++;
          check("completed runs at start_comp", int'(pc_m) + int'(fc_m), nfft - 1);
          checks++;
          if (exp_comp_q.size() == 0) begin
            errors++;
            $display("FAIL start_comp unexpected: got pulse at cycle %0d, expected none", cyc);
          end else begin
            checks--;
            check("start_comp cycle", cyc, exp_comp_q.pop_front());
          end
        end
        if (done_m && !done_prev) begin
          n_done++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done unexpected: got done at cycle %0d, expected none", cyc);
          end else begin
            checks--;
            e = exp_q.pop_front();
            check("pass_count at done", int'(pc_m), e.pass);
            check("fail_count at done", int'(fc_m), e.fail);
            check("run_idx at done", int'(ri_m), e.ridx);
            check("timeout_err at done", int'(terr_m), e.terr);
            check("busy at done", int'(busy_m), 0);
            check("start_fft pulses", nfft, e.nfft);
            check("start_comp pulses", ncomp, e.ncomp);
            if (e.tdelta > 0) check("error latency", cyc - last_sf_cyc, e.tdelta);
          end
          nfft = 0;
          ncomp = 0;
        end
        if (done_m && start) pend_rerun = 1'b1;
      end
      sf_prev = sf_m;
      sc_prev = sc_m;
      done_prev = done_m;
    end
  end

  initial begin : watchdog_proc
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim_proc
    int n;
    repeat (3) tick();
    check("reset outputs dut1", int'({sf1, sc1, busy1, done1, terr1, ri1, pc1, fc1}), 0);
    check("reset outputs dut2", int'({sf2, sc2, busy2, done2, terr2, ri2, pc2, fc2}), 0);
    rst = 1'b0;
    tick();

    queue_plan(R1, 1'b0, -1);
    pulse_start();
    wait_done(1, 2000, "all pass");

    queue_plan(R1, 1'b0, 2);
    pulse_start();
    wait_done(2, 2000, "one fail");

    fft_hang = 1'b1;
    exp_q.push_back('{pass: 0, fail: 0, ridx: 0, terr: 1, nfft: 1, ncomp: 0, tdelta: TO + 1});
    pulse_start();
    wait_done(3, 500, "fft timeout");
    fft_hang = 1'b0;
    repeat (20) tick();
    check("error state held", int'({done1, terr1, busy1}), 6);

    spur_en  = 1'b1;
    rand_lat = 1'b1;
    queue_plan(R1, 1'b1, -1);
    queue_plan(R1, 1'b1, -1);
    tick();
    start = 1'b1;
    wait_done(4, 2000, "held start first");
    repeat (10) tick();
    start = 1'b0;
    wait_done(5, 2000, "held start rerun");
    spur_en = 1'b0;

    for (int k = 0; k < 3; k++) begin
      queue_plan(R1, 1'b1, -1);
      pulse_start();
      wait_done(6 + k, 2000, "random episode");
    end

    rand_lat = 1'b0;
    verdict_q.push_back(1'b1);
    pulse_start();
    n = 0;
    while (ncomp < 1 && n < 200) begin
      tick();
      n++;
    end
    check("start_comp before reset", ncomp, 1);
    repeat (5) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", int'({sf1, sc1, busy1, done1, terr1, ri1, pc1, fc1}), 0);
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (chk_active && n < 100) begin
      tick();
      n++;
    end
    check("checker model idle", int'(chk_active), 0);
    repeat (3) tick();
    check("counts after late comp_done", int'(pc1) + int'(fc1), 0);
    check("idle after reset", int'({busy1, done1}), 0);

    sel = 1'b1;
    tick();
    queue_plan(R2, 1'b0, -1);
    pulse_start();
    wait_done(9, 500, "settle zero");
    repeat (3) tick();

    check("leftover expectations", exp_q.size() + exp_comp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
